// File: rtl/otter_csr_pkg.sv
// Shared CSR addresses, mstatus bit positions and CSR operation encoding for the
// OTTER machine-mode CSR / interrupt controller.
package otter_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    typedef enum logic [2:0] {
        CSR_RW = 3'b001,
        CSR_RS = 3'b010,
        CSR_RC = 3'b011
    } csr_op_t;

    // Read-modify-write result for a CSR instruction; unknown ops leave the value alone.
    function automatic logic [31:0] csr_apply(input logic [2:0] op,
                                              input logic [31:0] old_val,
                                              input logic [31:0] wd);
        logic [31:0] res;
        case (op)
            CSR_RW:  res = wd;
            CSR_RS:  res = old_val | wd;
            CSR_RC:  res = old_val & ~wd;
            default: res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/intr_sync_edge.sv
// Multi-flop synchronizer for the asynchronous external interrupt line followed by
// an edge flop; emits a registered one-cycle pulse on each synchronized rising edge.
module intr_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic RST,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   edge_r;
    logic                   rise_r;
    logic                   sync_out_s;

    assign sync_out_s = sync_r[SYNC_STAGES-1];

    // Synchronizer chain, edge history and registered rise pulse.
    always_ff @(posedge clk) begin
        if (RST) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            edge_r <= 1'b0;
            rise_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
            edge_r <= sync_out_s;
            rise_r <= sync_out_s & ~edge_r;
        end
    end

    assign rise = rise_r;

endmodule

// File: rtl/otter_csr_intr_ctrl.sv
// Machine-mode CSR file (mstatus, mtvec, mepc, mcause) and external interrupt
// request logic for the OTTER multicycle core.
module otter_csr_intr_ctrl
    import otter_csr_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] MCAUSE_EXT  = 32'h8000_000B
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        ext_intr,
    input  logic        csr_WE,
    input  logic [2:0]  func3,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wd,
    input  logic [31:0] pc,
    input  logic        int_taken,
    input  logic        mret_exec,
    output logic        intr,
    output logic [31:0] mtvec,
    output logic [31:0] mepc,
    output logic [31:0] csr_rd
);

    logic        mie_r, mpie_r, pending_r;
    logic [31:2] mtvec_r, mepc_r;
    logic [31:0] mcause_r;

    logic        mie_nxt_s, mpie_nxt_s, pending_nxt_s;
    logic [31:2] mtvec_nxt_s, mepc_nxt_s;
    logic [31:0] mcause_nxt_s;
    logic        rise_s, wr_en_s;
    logic [31:0] wr_val_s;
    logic        unused_pc_s;

    assign unused_pc_s = &pc[1:0];

    intr_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .RST      (RST),
        .async_in (ext_intr),
        .rise     (rise_s)
    );

    // Combinational CSR read of the pre-write value.
    always_comb begin
        csr_rd = 32'h0000_0000;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_rd[MSTATUS_MIE_BIT]  = mie_r;
                csr_rd[MSTATUS_MPIE_BIT] = mpie_r;
            end
            CSR_MTVEC:  csr_rd = {mtvec_r, 2'b00};
            CSR_MEPC:   csr_rd = {mepc_r, 2'b00};
            CSR_MCAUSE: csr_rd = mcause_r;
            default:    csr_rd = 32'h0000_0000;
        endcase
    end

    // Software write qualification; invalid func3 codes never write.
    always_comb begin
        wr_val_s = csr_apply(func3, csr_rd, csr_wd);
        case (func3)
            CSR_RW, CSR_RS, CSR_RC: wr_en_s = csr_WE;
            default:                wr_en_s = 1'b0;
        endcase
    end

    // Next-state: trap entry beats MRET beats software writes.
    always_comb begin
        mie_nxt_s    = mie_r;
        mpie_nxt_s   = mpie_r;
        mtvec_nxt_s  = mtvec_r;
        mepc_nxt_s   = mepc_r;
        mcause_nxt_s = mcause_r;
        if (int_taken) begin
            mepc_nxt_s   = pc[31:2];
            mcause_nxt_s = MCAUSE_EXT;
            mpie_nxt_s   = mie_r;
            mie_nxt_s    = 1'b0;
        end else if (mret_exec) begin
            mie_nxt_s    = mpie_r;
            mpie_nxt_s   = 1'b1;
        end else if (wr_en_s) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mie_nxt_s  = wr_val_s[MSTATUS_MIE_BIT];
                    mpie_nxt_s = wr_val_s[MSTATUS_MPIE_BIT];
                end
                CSR_MTVEC:  mtvec_nxt_s  = wr_val_s[31:2];
                CSR_MEPC:   mepc_nxt_s   = wr_val_s[31:2];
                CSR_MCAUSE: mcause_nxt_s = wr_val_s;
                default:    mcause_nxt_s = mcause_r;
            endcase
        end else begin
            mie_nxt_s = mie_r;
        end
    end

    // A new edge must never be lost, so it wins over a simultaneous acknowledge.
    always_comb begin
        if (rise_s) begin
            pending_nxt_s = 1'b1;
        end else if (int_taken) begin
            pending_nxt_s = 1'b0;
        end else begin
            pending_nxt_s = pending_r;
        end
    end

    // CSR and pending state registers.
    always_ff @(posedge clk) begin
        if (RST) begin
            mie_r     <= 1'b0;
            mpie_r    <= 1'b0;
            pending_r <= 1'b0;
            mtvec_r   <= 30'h0;
            mepc_r    <= 30'h0;
            mcause_r  <= 32'h0000_0000;
        end else begin
            mie_r     <= mie_nxt_s;
            mpie_r    <= mpie_nxt_s;
            pending_r <= pending_nxt_s;
            mtvec_r   <= mtvec_nxt_s;
            mepc_r    <= mepc_nxt_s;
            mcause_r  <= mcause_nxt_s;
        end
    end

    assign intr  = pending_r & mie_r;
    assign mtvec = {mtvec_r, 2'b00};
    assign mepc  = {mepc_r, 2'b00};

endmodule

// File: tb/tb_otter_csr_intr_ctrl.sv
// Scenario tests plus randomized traffic for otter_csr_intr_ctrl against a
// behavioural model built from the CSR and interrupt rules.
module tb_otter_csr_intr_ctrl;

    logic        clk = 1'b0;
    logic        RST, ext_intr, csr_WE, int_taken, mret_exec;
    logic [2:0]  func3;
    logic [11:0] csr_addr;
    logic [31:0] csr_wd, pc;
    logic        intr;
    logic [31:0] mtvec, mepc, csr_rd;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    logic        m_mie, m_mpie, m_pend;
    logic [31:0] m_mtvec, m_mepc, m_mcause;
    logic [4:0]  m_hist;   // ext_intr as seen at the last five posedges, [0] newest

    otter_csr_intr_ctrl dut (
        .clk(clk), .RST(RST), .ext_intr(ext_intr), .csr_WE(csr_WE), .func3(func3),
        .csr_addr(csr_addr), .csr_wd(csr_wd), .pc(pc), .int_taken(int_taken),
        .mret_exec(mret_exec), .intr(intr), .mtvec(mtvec), .mepc(mepc), .csr_rd(csr_rd)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return {24'h0, m_mpie, 3'b000, m_mie, 3'b000};
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            default: return 32'h0;
        endcase
    endfunction

    // One clock: advance the model with the inputs the DUT sampled, then settle.
    task automatic tick();
        logic [31:0] old_v, new_v;
        logic        rise;
        @(posedge clk);
        if (RST) begin
            m_mie = 1'b0; m_mpie = 1'b0; m_pend = 1'b0;
            m_mtvec = 32'h0; m_mepc = 32'h0; m_mcause = 32'h0;
            m_hist = 5'b0;
        end else begin
            m_hist = {m_hist[3:0], ext_intr};
            // An edge first sampled k-3 edges ago registers as pending now.
            rise  = m_hist[3] & ~m_hist[4];
            old_v = m_read(csr_addr);
            if (int_taken) begin
                m_mepc = pc & 32'hFFFF_FFFC;
                m_mcause = 32'h8000_000B;
                m_mpie = m_mie;
                m_mie = 1'b0;
            end else if (mret_exec) begin
                m_mie = m_mpie;
                m_mpie = 1'b1;
            end else if (csr_WE && func3 >= 3'd1 && func3 <= 3'd3) begin
                if (func3 == 3'd1)      new_v = csr_wd;
                else if (func3 == 3'd2) new_v = old_v | csr_wd;
                else                    new_v = old_v & ~csr_wd;
                case (csr_addr)
                    12'h300: begin m_mie = new_v[3]; m_mpie = new_v[7]; end
                    12'h305: m_mtvec = new_v & 32'hFFFF_FFFC;
                    12'h341: m_mepc = new_v & 32'hFFFF_FFFC;
                    12'h342: m_mcause = new_v;
                    default: ;
                endcase
            end
            if (rise) m_pend = 1'b1;
            else if (int_taken) m_pend = 1'b0;
        end
        #1;
    endtask

    task automatic idle();
        csr_WE = 1'b0; func3 = 3'd0; csr_wd = 32'h0;
        int_taken = 1'b0; mret_exec = 1'b0;
    endtask

    task automatic set_csr(input logic [2:0] op, input logic [11:0] a, input logic [31:0] wd);
        csr_WE = 1'b1; func3 = op; csr_addr = a; csr_wd = wd;
    endtask

    task automatic test_reset();
        logic [11:0] addrs [4] = '{12'h300, 12'h305, 12'h341, 12'h342};
        RST = 1'b1; ext_intr = 1'b0; pc = 32'h0; csr_addr = 12'h0; idle();
        tick(); tick();
        RST = 1'b0;
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL reset_intr got %0b want 0", intr); end
        checks++; if (mtvec !== 32'h0) begin errors++; $display("FAIL reset_mtvec got %h want 0", mtvec); end
        checks++; if (mepc !== 32'h0) begin errors++; $display("FAIL reset_mepc got %h want 0", mepc); end
        foreach (addrs[i]) begin
            csr_addr = addrs[i]; #1;
            checks++;
            if (csr_rd !== 32'h0) begin
                errors++; $display("FAIL reset_read[%h] got %h want 0", addrs[i], csr_rd);
            end
        end
    endtask

    task automatic test_mtvec_write();
        logic [11:0] addrs [3] = '{12'h300, 12'h341, 12'h342};
        set_csr(3'b001, 12'h305, 32'h0000_0103); tick(); idle();
        checks++; if (mtvec !== 32'h0000_0100) begin errors++; $display("FAIL mtvec_out got %h want 00000100", mtvec); end
        checks++; if (csr_rd !== 32'h0000_0100) begin errors++; $display("FAIL mtvec_read got %h want 00000100", csr_rd); end
        foreach (addrs[i]) begin
            csr_addr = addrs[i]; #1;
            checks++;
            if (csr_rd !== 32'h0) begin
                errors++; $display("FAIL other_read[%h] got %h want 0", addrs[i], csr_rd);
            end
        end
    endtask

    task automatic test_intr_entry();
        set_csr(3'b010, 12'h300, 32'h8); tick(); idle();
        checks++; if (csr_rd !== 32'h8) begin errors++; $display("FAIL mie_set got %h want 00000008", csr_rd); end
        ext_intr = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (intr !== (i == 4)) begin
                errors++; $display("FAIL intr_latency cycle %0d got %0b want %0b", i, intr, (i == 4));
            end
        end
        int_taken = 1'b1; pc = 32'h44; tick(); idle();
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL entry_intr got %0b want 0", intr); end
        checks++; if (mepc !== 32'h44) begin errors++; $display("FAIL entry_mepc got %h want 00000044", mepc); end
        csr_addr = 12'h342; #1;
        checks++; if (csr_rd !== 32'h8000_000B) begin errors++; $display("FAIL entry_mcause got %h want 8000000b", csr_rd); end
        csr_addr = 12'h300; #1;
        checks++; if (csr_rd !== 32'h80) begin errors++; $display("FAIL entry_mstatus got %h want 00000080", csr_rd); end
    endtask

    task automatic test_mret_level();
        mret_exec = 1'b1; tick(); idle();
        checks++; if (csr_rd !== 32'h88) begin errors++; $display("FAIL mret_mstatus got %h want 00000088", csr_rd); end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (intr !== 1'b0) begin errors++; $display("FAIL level_no_retrigger cycle %0d got %0b want 0", i, intr); end
        end
    endtask

    task automatic test_masked();
        set_csr(3'b011, 12'h300, 32'h8); tick(); idle();
        ext_intr = 1'b0; repeat (5) tick();
        ext_intr = 1'b1; tick(); tick(); ext_intr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (intr !== 1'b0) begin errors++; $display("FAIL masked cycle %0d got %0b want 0", i, intr); end
        end
        set_csr(3'b010, 12'h300, 32'h8); tick(); idle();
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL unmask_intr got %0b want 1", intr); end
        int_taken = 1'b1; tick(); idle();
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL masked_take got %0b want 0", intr); end
    endtask

    task automatic test_coincide();
        set_csr(3'b010, 12'h300, 32'h8); tick(); idle();
        ext_intr = 1'b0; repeat (5) tick();
        ext_intr = 1'b1; repeat (3) tick();
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL coincide_pre got %0b want 0", intr); end
        int_taken = 1'b1; tick(); idle();
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL coincide_entry got %0b want 0", intr); end
        mret_exec = 1'b1; tick(); idle();
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL coincide_reassert got %0b want 1", intr); end
    endtask

    task automatic test_back_to_back();
        int_taken = 1'b1; pc = 32'h0000_0123;
        set_csr(3'b001, 12'h341, 32'hDEAD_0000); tick(); idle();
        checks++; if (mepc !== 32'h0000_0120) begin errors++; $display("FAIL prio_mepc got %h want 00000120", mepc); end
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL prio_intr got %0b want 0", intr); end
        mret_exec = 1'b1; tick(); idle();
        ext_intr = 1'b0; repeat (5) tick();
        ext_intr = 1'b1; repeat (4) tick();
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL pend_before_rst got %0b want 1", intr); end
        RST = 1'b1; ext_intr = 1'b0; tick(); RST = 1'b0;
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL rst_intr got %0b want 0", intr); end
        checks++; if (mepc !== 32'h0) begin errors++; $display("FAIL rst_mepc got %h want 0", mepc); end
        checks++; if (mtvec !== 32'h0) begin errors++; $display("FAIL rst_mtvec got %h want 0", mtvec); end
        csr_addr = 12'h342; #1;
        checks++; if (csr_rd !== 32'h0) begin errors++; $display("FAIL rst_mcause got %h want 0", csr_rd); end
        csr_addr = 12'h300; #1;
        checks++; if (csr_rd !== 32'h0) begin errors++; $display("FAIL rst_mstatus got %h want 0", csr_rd); end
    endtask

    task automatic test_random();
        logic [11:0] addr_pool [5] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h7C0};
        for (int cyc = 0; cyc < 600; cyc++) begin
            RST       = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 5) == 0) ext_intr = ~ext_intr;
            int_taken = ($urandom_range(0, 11) == 0);
            mret_exec = ($urandom_range(0, 11) == 0);
            csr_WE    = ($urandom_range(0, 2) == 0);
            func3     = 3'($urandom_range(0, 7));
            csr_addr  = addr_pool[$urandom_range(0, 4)];
            case ($urandom_range(0, 3))
                0:       csr_wd = 32'h0;
                1:       csr_wd = 32'h8;
                2:       csr_wd = 32'h88;
                default: csr_wd = $urandom;
            endcase
            pc = $urandom;
            tick();
            checks++;
            if (intr !== (m_pend & m_mie)) begin
                errors++; $display("FAIL rand_intr cyc %0d got %0b want %0b", cyc, intr, m_pend & m_mie);
            end
            checks++;
            if (mtvec !== m_mtvec) begin
                errors++; $display("FAIL rand_mtvec cyc %0d got %h want %h", cyc, mtvec, m_mtvec);
            end
            checks++;
            if (mepc !== m_mepc) begin
                errors++; $display("FAIL rand_mepc cyc %0d got %h want %h", cyc, mepc, m_mepc);
            end
            checks++;
            if (csr_rd !== m_read(csr_addr)) begin
                errors++; $display("FAIL rand_csr_rd cyc %0d addr %h got %h want %h",
                                   cyc, csr_addr, csr_rd, m_read(csr_addr));
            end
        end
        RST = 1'b0; idle();
    endtask

    initial begin
        m_mie = 1'b0; m_mpie = 1'b0; m_pend = 1'b0;
        m_mtvec = 32'h0; m_mepc = 32'h0; m_mcause = 32'h0; m_hist = 5'b0;
        test_reset();
        test_mtvec_write();
        test_intr_entry();
        test_mret_level();
        test_masked();
        test_coincide();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
